// File: rtl/alu_op_sequencer.sv
// Front-end controller for the ALU: gathers operand A, operand B and opcode from the switch bus
// on enter strobes, runs the ALU for EXEC_WAIT cycles, captures the result and supports chaining.
module alu_op_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enter,
  input  logic              clear,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_y,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              carry,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Counter only needs to hold EXEC_WAIT-1.
  localparam int unsigned CntW = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(EXEC_WAIT - 1);

  typedef enum logic [2:0] {
    StA    = 3'd0,
    StB    = 3'd1,
    StOp   = 3'd2,
    StExec = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StA;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    // clear overrides everything, including a capture due this cycle
    if (clear) begin
      state_d = StA;
      carry_d = 1'b0;
    end else begin
      case (state_q)
        StA: begin
          if (enter) begin
            a_d     = data_in;
            state_d = StB;
          end
        end
        StB: begin
          if (enter) begin
            b_d     = data_in;
            state_d = StOp;
          end
        end
        StOp: begin
          if (enter) begin
            sel_d   = data_in[1:0];
            cnt_d   = CntLoad;
            state_d = StExec;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            result_d = alu_y;
            // unsigned add wrapped iff the sum is smaller than an addend
            carry_d  = (sel_q == 2'b01) && (alu_y < a_q);
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StDone: begin
          if (enter) begin
            a_d     = result_q;
            b_d     = data_in;
            state_d = StOp;
          end
        end
        default: state_d = StA;
      endcase
    end
  end

  assign alu_num1     = a_q;
  assign alu_num2     = b_q;
  assign alu_sel      = {1'b0, sel_q};
  assign result       = result_q;
  assign carry        = carry_q;
  assign result_valid = (state_q == StDone);
  assign busy         = (state_q == StExec);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of operand/opcode vectors plus hand-written
// sequences for chaining, busy-time strobes, clear/enter collision and async reset.
module tb_alu_op_sequencer;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned EXEC_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              enter;
  logic              clear;
  logic [DATA_W-1:0] alu_num1;
  logic [DATA_W-1:0] alu_num2;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              carry;
  logic              busy;
  logic [2:0]        state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DATA_W   (DATA_W),
    .EXEC_WAIT(EXEC_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .enter       (enter),
    .clear       (clear),
    .alu_num1    (alu_num1),
    .alu_num2    (alu_num2),
    .alu_sel     (alu_sel),
    .alu_y       (alu_y),
    .result      (result),
    .result_valid(result_valid),
    .carry       (carry),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Reference ALU
  always_comb begin
    case (alu_sel[1:0])
      2'b11:   alu_y = alu_num1 & alu_num2;
      2'b10:   alu_y = alu_num1 | alu_num2;
      2'b01:   alu_y = alu_num1 + alu_num2;
      default: alu_y = '0;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp_result;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_enter(input logic [7:0] d);
    data_in = d;
    enter   = 1'b1;
    @(posedge clk);
    #1;
    enter   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!result_valid && n < int'(EXEC_WAIT) + 1) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("result_valid_timeout", {31'd0, result_valid}, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    do_enter(a);
    do_enter(b);
    do_enter(op);
    check("busy_after_op", {31'd0, busy}, 32'd1);
    wait_done();
  endtask

  logic [2:0] sel_before;

  initial begin
    vecs[0] = '{a: 8'h3C, b: 8'h0F, op: 8'h01, exp_result: 8'h4B, exp_carry: 1'b0};
    vecs[1] = '{a: 8'hF0, b: 8'h20, op: 8'h01, exp_result: 8'h10, exp_carry: 1'b1};
    vecs[2] = '{a: 8'hF0, b: 8'h20, op: 8'h03, exp_result: 8'h20, exp_carry: 1'b0};
    vecs[3] = '{a: 8'hF0, b: 8'h20, op: 8'h02, exp_result: 8'hF0, exp_carry: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, op: 8'h00, exp_result: 8'h00, exp_carry: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'h01, op: 8'h01, exp_result: 8'h00, exp_carry: 1'b1};
    vecs[6] = '{a: 8'hFE, b: 8'h01, op: 8'h01, exp_result: 8'hFF, exp_carry: 1'b0};

    rst     = 1'b1;
    data_in = '0;
    enter   = 1'b0;
    clear   = 1'b0;
    #2;
    check("reset_state", {29'd0, state_dbg}, 32'd0);
    check("reset_outputs", {alu_num1, alu_num2, result, 8'd0},
          32'd0);
    check("reset_flags", {26'd0, alu_sel, result_valid, carry, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_clear();
      check($sformatf("v%0d_cleared_state", i), {29'd0, state_dbg}, 32'd0);
      run_op(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].exp_result});
      check($sformatf("v%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].exp_carry});
      check($sformatf("v%0d_state", i), {29'd0, state_dbg}, 32'd4);
      check($sformatf("v%0d_sel", i), {29'd0, alu_sel}, {30'd0, vecs[i].op[1:0]});
    end

    // Chain: 0x4B + 0x05
    do_clear();
    run_op(8'h3C, 8'h0F, 8'h01);
    check("chain_first", {24'd0, result}, 32'h4B);
    do_enter(8'h05);
    check("chain_state_op", {29'd0, state_dbg}, 32'd2);
    check("chain_a", {24'd0, alu_num1}, 32'h4B);
    check("chain_b", {24'd0, alu_num2}, 32'h05);
    check("chain_valid_low", {31'd0, result_valid}, 32'd0);
    do_enter(8'h01);
    wait_done();
    check("chain_result", {24'd0, result}, 32'h50);
    check("chain_carry", {31'd0, carry}, 32'd0);

    // Enter strobes during EXEC are ignored
    do_clear();
    do_enter(8'hFF);
    do_enter(8'hFF);
    do_enter(8'h00);
    check("busy_state", {29'd0, state_dbg}, 32'd3);
    do_enter(8'hAA);
    check("busy_enter_ignored_state", {29'd0, state_dbg}, 32'd3);
    check("busy_enter_ignored_b", {24'd0, alu_num2}, 32'hFF);
    check("busy_enter_ignored_sel", {29'd0, alu_sel}, 32'd0);
    wait_done();
    check("op00_result", {24'd0, result}, 32'h00);
    check("op00_carry", {31'd0, carry}, 32'd0);
    check("op00_a_kept", {24'd0, alu_num1}, 32'hFF);

    // clear beats enter in S_OP; prior result/carry from ADD FF+01 first
    do_clear();
    run_op(8'hFF, 8'h01, 8'h01);
    check("pre_clear_carry", {31'd0, carry}, 32'd1);
    do_clear();
    check("clear_drops_carry", {31'd0, carry}, 32'd0);
    check("clear_keeps_result", {24'd0, result}, 32'h00);
    do_enter(8'h11);
    do_enter(8'h22);
    check("pre_collide_state", {29'd0, state_dbg}, 32'd2);
    sel_before = alu_sel;
    data_in = 8'h03;
    enter   = 1'b1;
    clear   = 1'b1;
    @(posedge clk);
    #1;
    enter = 1'b0;
    clear = 1'b0;
    check("collide_state", {29'd0, state_dbg}, 32'd0);
    check("collide_valid", {31'd0, result_valid}, 32'd0);
    check("collide_sel", {29'd0, alu_sel}, {29'd0, sel_before});
    check("collide_a", {24'd0, alu_num1}, 32'h11);
    check("collide_b", {24'd0, alu_num2}, 32'h22);
    @(posedge clk);
    #1;
    check("collide_stays_a", {29'd0, state_dbg}, 32'd0);

    // Async reset in the middle of EXEC
    do_enter(8'h12);
    do_enter(8'h34);
    do_enter(8'h01);
    check("mid_exec_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", {29'd0, state_dbg}, 32'd0);
    check("async_rst_data", {alu_num1, alu_num2, result, 8'd0}, 32'd0);
    check("async_rst_flags", {26'd0, alu_sel, result_valid, carry, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("post_rst_no_capture", {24'd0, result}, 32'd0);
    check("post_rst_state", {29'd0, state_dbg}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
